// File: rtl/stw_array_scheduler.sv
// Time-shares a systolic array between matmul jobs and periodic Stop-the-World
// self-tests, sequencing the STW handshake and keeping a sticky per-PE health map.
module stw_array_scheduler #(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int WORD_SIZE   = 8,
  parameter int TEST_PERIOD = 64,
  parameter int STW_TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   matmul_req,
  input  logic                   matmul_done,
  input  logic                   force_test,
  input  logic                   clear_faults,
  input  logic                   STW_complete,
  input  logic [ROWS*COLS-1:0]   STW_result_mat,
  output logic                   start_fsm,
  output logic                   STW_test_load_en,
  output logic                   STW_start,
  output logic [WORD_SIZE-1:0]   STW_mult_op1,
  output logic [WORD_SIZE-1:0]   STW_mult_op2,
  output logic [WORD_SIZE-1:0]   STW_add_op,
  output logic [WORD_SIZE-1:0]   STW_expected,
  output logic [ROWS*COLS-1:0]   health_map,
  output logic                   fault_detected,
  output logic                   stw_timeout_err,
  output logic                   busy
);

  localparam int NPE = ROWS * COLS;
  localparam int TW  = (TEST_PERIOD > 2) ? $clog2(TEST_PERIOD) : 1;
  localparam int WW  = (STW_TIMEOUT > 2) ? $clog2(STW_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TEST_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(STW_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATMUL,
    S_LOAD,
    S_START,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            test_due_q, test_due_d;
  logic            vec_q, vec_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [NPE-1:0]  health_q, health_d;
  logic            tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      test_due_q <= 1'b1;
      vec_q      <= 1'b0;
      wait_q     <= '0;
      health_q   <= '1;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      test_due_q <= test_due_d;
      vec_q      <= vec_d;
      wait_q     <= wait_d;
      health_q   <= health_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    test_due_d       = test_due_q;
    vec_d            = vec_q;
    wait_d           = wait_q;
    health_d         = health_q;
    tmo_d            = tmo_q;
    start_fsm        = 1'b0;
    STW_test_load_en = 1'b0;
    STW_start        = 1'b0;

    // The period only runs while the array is not under test; it saturates at the top.
    if ((state_q == S_IDLE || state_q == S_MATMUL) && timer_q != TIMER_MAX) begin
      timer_d = timer_q + TW'(1);
      if (timer_q + TW'(1) == TIMER_MAX) test_due_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (test_due_q)      state_d = S_LOAD;
        else if (matmul_req) state_d = S_MATMUL;
      end
      S_MATMUL: begin
        start_fsm = 1'b1;
        if (matmul_done) state_d = S_IDLE;
      end
      S_LOAD: begin
        STW_test_load_en = 1'b1;
        state_d          = S_START;
      end
      S_START: begin
        STW_start = 1'b1;
        wait_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + WW'(1);
        if (STW_complete) begin
          health_d = health_q & STW_result_mat;
          vec_d    = ~vec_q;
          state_d  = S_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          tmo_d   = 1'b1;
          vec_d   = ~vec_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD && state_q != S_LOAD) begin
      test_due_d = 1'b0;
      timer_d    = '0;
    end
    if (force_test) test_due_d = 1'b1;
    // A clear beats a capture in the same cycle; the next test re-accumulates.
    if (clear_faults) begin
      health_d = '1;
      tmo_d    = 1'b0;
    end
  end

  always_comb begin
    STW_mult_op1 = '0;
    STW_mult_op2 = '0;
    STW_add_op   = '0;
    STW_expected = '0;
    if (state_q == S_LOAD || state_q == S_START || state_q == S_WAIT) begin
      if (vec_q) begin
        STW_mult_op1 = WORD_SIZE'(5);
        STW_mult_op2 = WORD_SIZE'(7);
        STW_add_op   = WORD_SIZE'(2);
        STW_expected = WORD_SIZE'(37);
      end else begin
        STW_mult_op1 = WORD_SIZE'(4);
        STW_mult_op2 = WORD_SIZE'(3);
        STW_add_op   = WORD_SIZE'(0);
        STW_expected = WORD_SIZE'(12);
      end
    end
  end

  assign health_map      = health_q;
  assign fault_detected  = |(~health_q);
  assign stw_timeout_err = tmo_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_stw_array_scheduler.sv
// Scenario bench for stw_array_scheduler: test vectors are queued when a test is
// made due and checked when the load strobe appears; health/error state is modelled.
module tb_stw_array_scheduler;

  logic       clk = 1'b0;
  logic       rst, matmul_req, matmul_done, force_test, clear_faults, STW_complete;
  logic [8:0] STW_result_mat;
  logic       start_fsm, STW_test_load_en, STW_start;
  logic [7:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic [8:0] health_map;
  logic       fault_detected, stw_timeout_err, busy;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic        vec_m;
  logic [8:0]  health_m;
  logic        err_m;

  stw_array_scheduler #(
    .ROWS(3), .COLS(3), .WORD_SIZE(8), .TEST_PERIOD(64), .STW_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .matmul_req(matmul_req), .matmul_done(matmul_done),
    .force_test(force_test), .clear_faults(clear_faults), .STW_complete(STW_complete),
    .STW_result_mat(STW_result_mat), .start_fsm(start_fsm),
    .STW_test_load_en(STW_test_load_en), .STW_start(STW_start),
    .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op),
    .STW_expected(STW_expected), .health_map(health_map), .fault_detected(fault_detected),
    .stw_timeout_err(stw_timeout_err), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] vec_of(input logic idx);
    return idx ? {8'd5, 8'd7, 8'd2, 8'd37} : {8'd4, 8'd3, 8'd0, 8'd12};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_vec();
    exp_q.push_back(vec_of(vec_m));
  endtask

  task automatic pulse_force();
    force_test = 1'b1;
    tick();
    force_test = 1'b0;
  endtask

  task automatic model_reset();
    vec_m    = 1'b0;
    health_m = 9'h1FF;
    err_m    = 1'b0;
  endtask

  task automatic wait_load(input string name, input int max, output int n);
    logic [31:0] exp_v, got;
    n = 0;
    do begin
      tick();
      n++;
    end while (!STW_test_load_en && n < max);
    compared++;
    if (STW_test_load_en !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_load: load_en=%0b after %0d cycles, required 1", name, STW_test_load_en, n);
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    got = {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected};
    compared++;
    if (got !== exp_v) begin
      mismatched++;
      $display("FAIL %s_vector: got %h, required %h", name, got, exp_v);
    end
  endtask

  // Called with the DUT in LOAD; finishes on the cycle it is back in IDLE.
  task automatic run_test(input string name, input int delay, input logic [8:0] res,
                          input bit tmo, input bit clr);
    int n;
    tick();
    compared++;
    if ({STW_test_load_en, STW_start, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}
        !== {1'b0, 1'b1, vec_of(vec_m)}) begin
      mismatched++;
      $display("FAIL %s_start: load=%0b start=%0b ops=%h, required load=0 start=1 ops=%h",
               name, STW_test_load_en, STW_start,
               {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, vec_of(vec_m));
    end
    tick();
    compared++;
    if ({STW_test_load_en, STW_start, busy} !== 3'b001) begin
      mismatched++;
      $display("FAIL %s_wait: load/start/busy=%b, required 001", name,
               {STW_test_load_en, STW_start, busy});
    end
    if (tmo) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (busy && n < 40);
      err_m = 1'b1;
      vec_m = ~vec_m;
      compared++;
      if (n != 32) begin
        mismatched++;
        $display("FAIL %s_wait_cycles: %0d cycles in wait, required 32", name, n);
      end
      compared++;
      if ({STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected} !== 32'h0) begin
        mismatched++;
        $display("FAIL %s_ops_idle: ops=%h, required 0", name,
                 {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected});
      end
    end else begin
      repeat (delay) tick();
      STW_complete = 1'b1;
      STW_result_mat = res;
      clear_faults = clr;
      tick();
      STW_complete = 1'b0;
      STW_result_mat = 9'h0;
      clear_faults = 1'b0;
      health_m = clr ? 9'h1FF : (health_m & res);
      if (clr) err_m = 1'b0;
      vec_m = ~vec_m;
      compared++;
      if (busy !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_done_idle: busy=%0b, required 0", name, busy);
      end
    end
    compared++;
    if ({health_map, fault_detected, stw_timeout_err} !== {health_m, |(~health_m), err_m}) begin
      mismatched++;
      $display("FAIL %s_health: map=%h fault=%0b err=%0b, required map=%h fault=%0b err=%0b",
               name, health_map, fault_detected, stw_timeout_err,
               health_m, |(~health_m), err_m);
    end
  endtask

  task automatic check_reset_values(input string name);
    compared++;
    if ({busy, start_fsm, STW_test_load_en, STW_start} !== 4'b0000) begin
      mismatched++;
      $display("FAIL %s_ctrl: busy/start_fsm/load/start=%b, required 0000", name,
               {busy, start_fsm, STW_test_load_en, STW_start});
    end
    compared++;
    if ({STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected} !== 32'h0) begin
      mismatched++;
      $display("FAIL %s_ops: ops=%h, required 0", name,
               {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected});
    end
    compared++;
    if ({health_map, fault_detected, stw_timeout_err} !== {9'h1FF, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL %s_health: map=%h fault=%0b err=%0b, required 1ff 0 0", name,
               health_map, fault_detected, stw_timeout_err);
    end
  endtask

  task automatic check_n(input string name, input int n, input int req);
    compared++;
    if (n != req) begin
      mismatched++;
      $display("FAIL %s: got %0d cycles, required %0d", name, n, req);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; matmul_req = 1'b0; matmul_done = 1'b0; force_test = 1'b0;
    clear_faults = 1'b0; STW_complete = 1'b0; STW_result_mat = 9'h0;
    model_reset();
    tick();
    tick();
    check_reset_values("reset");
  endtask

  task automatic test_first_test();
    int n;
    matmul_req = 1'b1;
    push_vec();
    rst = 1'b0;
    wait_load("first", 4, n);
    check_n("first_latency", n, 1);
    run_test("first", 1, 9'h1FF, 1'b0, 1'b0);
    tick();
    compared++;
    if (start_fsm !== 1'b1) begin
      mismatched++;
      $display("FAIL first_grant: start_fsm=%0b, required 1", start_fsm);
    end
  endtask

  task automatic test_matmul_hold();
    int n, bad;
    bad = 0;
    repeat (100) begin
      tick();
      if (start_fsm !== 1'b1 || STW_test_load_en !== 1'b0) bad++;
    end
    check_n("hold_no_preempt_bad", bad, 0);
    push_vec();
    matmul_done = 1'b1;
    tick();
    matmul_done = 1'b0;
    compared++;
    if ({start_fsm, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL hold_release: start_fsm/busy=%b, required 00", {start_fsm, busy});
    end
    wait_load("hold", 3, n);
    check_n("hold_latency", n, 1);
    matmul_req = 1'b0;
    run_test("bad_pe", 2, 9'h1EF, 1'b0, 1'b0);
    push_vec();
    pulse_force();
    wait_load("sticky", 3, n);
    run_test("sticky", 0, 9'h1FF, 1'b0, 1'b0);
    clear_faults = 1'b1;
    tick();
    clear_faults = 1'b0;
    health_m = 9'h1FF;
    compared++;
    if ({health_map, fault_detected} !== {9'h1FF, 1'b0}) begin
      mismatched++;
      $display("FAIL clear_faults: map=%h fault=%0b, required 1ff 0", health_map, fault_detected);
    end
  endtask

  task automatic test_timeout();
    int n;
    push_vec();
    pulse_force();
    wait_load("timeout", 3, n);
    check_n("force_latency", n, 1);
    run_test("timeout", 0, 9'h0, 1'b1, 1'b0);
    push_vec();
    pulse_force();
    wait_load("after_timeout", 3, n);
    run_test("after_timeout", 0, 9'h1FF, 1'b0, 1'b0);
  endtask

  task automatic test_period();
    int n, t0;
    push_vec();
    wait_load("period1", 80, n);
    check_n("period_idle_to_load", n, 64);
    t0 = cyc;
    run_test("period1", 3, 9'h1FF, 1'b0, 1'b0);
    push_vec();
    wait_load("period2", 80, n);
    check_n("period_load_to_load", cyc - t0, 70);
    run_test("clear_priority", 0, 9'h0FF, 1'b0, 1'b1);
  endtask

  task automatic test_force_in_matmul();
    int n;
    matmul_req = 1'b1;
    tick();
    compared++;
    if (start_fsm !== 1'b1) begin
      mismatched++;
      $display("FAIL fim_grant: start_fsm=%0b, required 1", start_fsm);
    end
    push_vec();
    pulse_force();
    repeat (3) tick();
    compared++;
    if ({start_fsm, STW_test_load_en} !== 2'b10) begin
      mismatched++;
      $display("FAIL fim_wait: start_fsm/load=%b, required 10", {start_fsm, STW_test_load_en});
    end
    matmul_done = 1'b1;
    tick();
    matmul_done = 1'b0;
    matmul_req = 1'b0;
    compared++;
    if ({busy, STW_test_load_en} !== 2'b00) begin
      mismatched++;
      $display("FAIL fim_idle: busy/load=%b, required 00", {busy, STW_test_load_en});
    end
    wait_load("fim", 3, n);
    check_n("fim_latency", n, 1);
    run_test("fim", 1, 9'h0FE, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    push_vec();
    pulse_force();
    wait_load("rst_wait", 3, n);
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    check_reset_values("rst_in_wait");
    matmul_req = 1'b1;
    push_vec();
    rst = 1'b0;
    wait_load("rst_wait_after", 3, n);
    check_n("rst_wait_test_first", n, 1);
    run_test("rst_wait_after", 0, 9'h1FF, 1'b0, 1'b0);
    tick();
    compared++;
    if (start_fsm !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mm_grant: start_fsm=%0b, required 1", start_fsm);
    end
    rst = 1'b1;
    tick();
    model_reset();
    check_reset_values("rst_in_matmul");
    push_vec();
    rst = 1'b0;
    wait_load("rst_mm_after", 3, n);
    check_n("rst_mm_test_first", n, 1);
    matmul_req = 1'b0;
    run_test("rst_mm_after", 0, 9'h1FF, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_test();
    test_matmul_hold();
    test_timeout();
    test_period();
    test_force_in_matmul();
    test_reset_mid();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
